// File: rtl/set_counter_multi.sv
// set_counter_multi: scans a GRID x GRID lattice and counts points matching a set operation on circles A, B, C.
// Optional macro SET_DIST_PIPE_EN registers the squared distances before compare/accumulate.
module set_counter_multi #(
    parameter int COORD_W = 4,
    parameter int GRID    = 8,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [6*COORD_W-1:0] central,
    input  logic [3*COORD_W-1:0] radius,
    input  logic [2:0]           mode,
    output logic                 busy,
    output logic                 valid,
    output logic [CNT_W-1:0]     candidate
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    localparam logic [COORD_W-1:0] G = COORD_W'(GRID);
    localparam int SW = 2*COORD_W+1;

    state_t               state_q, state_d;
    logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
    logic [6*COORD_W-1:0] cen_q, cen_d;
    logic [3*COORD_W-1:0] rad_q, rad_d;
    logic [2:0]           mode_q, mode_d;
    logic [CNT_W-1:0]     acc_q, acc_d, cand_q, cand_d;
    logic                 busy_q, busy_d, valid_q, valid_d;
    logic [SW-1:0]        sum_c [3];
    logic [SW-1:0]        sum_e [3];
    logic [2:0]           in_k;
    logic                 start, last, issue, acc_en, scan_end, hit;

    assign start = state_q == IDLE && en;
    assign last  = x_q == G && y_q == G;

    for (genvar k = 0; k < 3; k++) begin : g_circ
        logic [COORD_W-1:0]   xc, yc, rc, dx, dy;
        logic [2*COORD_W-1:0] dxe, dye, rce;
        assign xc  = cen_q[(5-2*k)*COORD_W +: COORD_W];
        assign yc  = cen_q[(4-2*k)*COORD_W +: COORD_W];
        assign rc  = rad_q[(2-k)*COORD_W +: COORD_W];
        assign dx  = x_q >= xc ? x_q - xc : xc - x_q;
        assign dy  = y_q >= yc ? y_q - yc : yc - y_q;
        assign dxe = {{COORD_W{1'b0}}, dx};
        assign dye = {{COORD_W{1'b0}}, dy};
        assign rce = {{COORD_W{1'b0}}, rc};
        assign sum_c[k] = {1'b0, dxe * dxe} + {1'b0, dye * dye};
`ifdef SET_DIST_PIPE_EN
        logic [SW-1:0] sum_q;
        always_ff @(posedge clk) sum_q <= rst ? '0 : sum_c[k];
        assign sum_e[k] = sum_q;
`else
        assign sum_e[k] = sum_c[k];
`endif
        assign in_k[k] = sum_e[k] <= {1'b0, rce * rce};
    end

`ifdef SET_DIST_PIPE_EN
    // The last issued point still sits in the pipe; fin_q holds SCAN one extra cycle to drain it.
    logic pv_q, fin_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            pv_q  <= 1'b0;
            fin_q <= 1'b0;
        end else begin
            pv_q  <= issue;
            fin_q <= issue && last;
        end
    end
    assign issue    = state_q == SCAN && !fin_q;
    assign acc_en   = pv_q;
    assign scan_end = fin_q;
`else
    assign issue    = state_q == SCAN;
    assign acc_en   = issue;
    assign scan_end = last;
`endif

    assign hit = mode_q == 3'd0 ? in_k[0] :
                 mode_q == 3'd1 ? in_k[0] & in_k[1] :
                 mode_q == 3'd2 ? in_k[0] ^ in_k[1] :
                 mode_q == 3'd3 ? in_k[0] | in_k[1] :
                 mode_q == 3'd4 ? (in_k[0] & in_k[1] & ~in_k[2]) | (in_k[0] & ~in_k[1] & in_k[2]) | (~in_k[0] & in_k[1] & in_k[2]) :
                 mode_q == 3'd5 ? &in_k : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cen_q   <= '0;
            rad_q   <= '0;
            mode_q  <= '0;
            acc_q   <= '0;
            cand_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cen_q   <= cen_d;
            rad_q   <= rad_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            cand_q  <= cand_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q == IDLE ? (en ? SCAN : IDLE) :
                  state_q == SCAN ? (scan_end ? DONE : SCAN) : IDLE;
    end

    always_comb begin
        cen_d  = start ? central : cen_q;
        rad_d  = start ? radius : rad_q;
        mode_d = start ? mode : mode_q;
        x_d    = start ? COORD_W'(1) : issue ? (x_q == G ? COORD_W'(1) : x_q + COORD_W'(1)) : x_q;
        y_d    = start ? COORD_W'(1) : issue && x_q == G ? y_q + COORD_W'(1) : y_q;
        acc_d  = start ? '0 : acc_en && hit && ~&acc_q ? acc_q + CNT_W'(1) : acc_q;
    end

    always_comb begin
        busy_d  = state_d != IDLE;
        valid_d = state_q == DONE;
        cand_d  = state_q == DONE ? acc_q : cand_q;
    end

    assign busy      = busy_q;
    assign valid     = valid_q;
    assign candidate = cand_q;
endmodule
